// File: rtl/arith_pkg.sv
// Shared widths and FSM encoding for the sequential arithmetic blocks.
package arith_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/srcs_subtractor.sv
// Square-root carry-select subtractor: diff = a - b computed as a + ~b + 1.
// Block widths grow 2,3,4,... so each block's select arrives as its sums settle.
module srcs_subtractor #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  function automatic int blk_lo(input int k);
    return 2 * k + (k * (k - 1)) / 2;
  endfunction

  function automatic int num_blocks();
    int k;
    k = 0;
    while (blk_lo(k) < WIDTH) k++;
    return k;
  endfunction

  localparam int NBLK = num_blocks();

  logic [WIDTH-1:0] b_n;
  logic [NBLK:0]    carry;

  assign b_n      = ~b_i;
  assign carry[0] = 1'b1;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = blk_lo(k);
    localparam int HI = ((blk_lo(k + 1) > WIDTH) ? WIDTH : blk_lo(k + 1)) - 1;
    localparam int BW = HI - LO + 1;

    logic [BW:0] sum0;
    logic [BW:0] sum1;

    // Both carry-in outcomes are formed up front; the incoming carry only selects.
    assign sum0 = {1'b0, a_i[HI:LO]} + {1'b0, b_n[HI:LO]};
    assign sum1 = sum0 + {{BW{1'b0}}, 1'b1};

    assign diff_o[HI:LO] = carry[k] ? sum1[BW-1:0] : sum0[BW-1:0];
    assign carry[k+1]    = carry[k] ? sum1[BW] : sum0[BW];
  end

  assign borrow_o = ~carry[NBLK];

endmodule

// File: rtl/seq_divider32_16.sv
// Radix-2 restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high only in IDLE, out_valid only in DONE.
module seq_divider32_16
  import arith_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero,
  output logic [1:0]            dbg_state_o
);

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] q_reg_q;
  logic [DIVISOR_W:0]    r_reg_q;
  logic [DIVISOR_W-1:0]  dsor_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  dz_q;

  logic [DIVISOR_W:0]    shift_d;
  logic [DIVISOR_W:0]    diff_w;
  logic                  borrow_w;
  logic [DIVISOR_W:0]    r_reg_d;
  logic [DIVIDEND_W-1:0] q_reg_d;

  srcs_subtractor #(.WIDTH(DIVISOR_W + 1)) u_sub (
    .a_i      (shift_d),
    .b_i      ({1'b0, dsor_q}),
    .diff_o   (diff_w),
    .borrow_o (borrow_w)
  );

  // Partial remainder stays below the divisor, so its top bit is always free for the shift.
  always_comb begin
    shift_d = {r_reg_q[DIVISOR_W-1:0], q_reg_q[DIVIDEND_W-1]};
    r_reg_d = borrow_w ? shift_d : diff_w;
    q_reg_d = {q_reg_q[DIVIDEND_W-2:0], ~borrow_w};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_reg_q <= '0;
      r_reg_q <= '0;
      dsor_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              dsor_q  <= divisor;
              q_reg_q <= dividend;
              r_reg_q <= '0;
              cnt_q   <= CNT_W'(DIVIDEND_W - 1);
              state_q <= CALC;
            end else begin
              quot_q  <= '1;
              rem_q   <= dividend[DIVISOR_W-1:0];
              dz_q    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          q_reg_q <= q_reg_d;
          r_reg_q <= r_reg_d;
          if (cnt_q == '0) begin
            quot_q  <= q_reg_d;
            rem_q   <= r_reg_d[DIVISOR_W-1:0];
            dz_q    <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_zero    = dz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider32_16.sv
// Bench for seq_divider32_16: scoreboard of reference results, one task per scenario.
module tb_seq_divider32_16;

  localparam int RES_W = 49;  // {div_zero, remainder[15:0], quotient[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic [1:0]  dbg_state;

  logic [RES_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  seq_divider32_16 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_zero    (div_zero),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] model(input logic [31:0] a, input logic [15:0] b);
    logic [31:0] q;
    logic [15:0] r;
    if (b == 16'd0) return {1'b1, a[15:0], 32'hFFFF_FFFF};
    q = a / {16'd0, b};
    r = 16'(a % {16'd0, b});
    return {1'b0, r, q};
  endfunction

  // Present operands until accepted; the accept edge has passed when this returns.
  task automatic drive_op(input logic [31:0] a, input logic [15:0] b, input bit push);
    int n;
    n = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
    end else begin
      @(posedge clk); #1;
      if (push) exp_q.push_back(model(a, b));
    end
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, compare against the scoreboard head, then complete the handshake.
  task automatic collect(input logic [31:0] a, input logic [15:0] b, output int lat);
    logic [RES_W-1:0] exp;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL result_timeout: out_valid=%0b required 1 within 200 cycles", out_valid);
      return;
    end
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_result: out_valid=1 required no pending result");
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (quotient !== exp[31:0]) begin
        failures++;
        $display("FAIL quotient %h/%h: got %h required %h", a, b, quotient, exp[31:0]);
      end
      checks++;
      if (remainder !== exp[47:32]) begin
        failures++;
        $display("FAIL remainder %h/%h: got %h required %h", a, b, remainder, exp[47:32]);
      end
      checks++;
      if (div_zero !== exp[48]) begin
        failures++;
        $display("FAIL div_zero %h/%h: got %0b required %0b", a, b, div_zero, exp[48]);
      end
    end
    if (b != 16'd0) begin
      checks++;
      if (!(remainder < b) || ({32'd0, quotient} * {48'd0, b} + {48'd0, remainder}) !== {32'd0, a}) begin
        failures++;
        $display("FAIL identity %h/%h: q=%h r=%h required q*d+r==dividend and r<d", a, b, quotient, remainder);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, div_zero, out_valid, in_ready, dbg_state} !== {32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_values: q=%h r=%h dz=%0b ov=%0b ir=%0b st=%0d required 0/0/0/0/1/0",
               quotient, remainder, div_zero, out_valid, in_ready, dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    drive_op(32'd100, 16'd7, 1'b1);
    collect(32'd100, 16'd7, lat);
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL latency_100_7: got %0d required 33", lat);
    end
    drive_op(32'hFFFF_FFFF, 16'h0001, 1'b1);
    collect(32'hFFFF_FFFF, 16'h0001, lat);
    drive_op(32'hFFFF_FFFF, 16'hFFFF, 1'b1);
    collect(32'hFFFF_FFFF, 16'hFFFF, lat);
  endtask

  task automatic test_div_zero();
    int lat;
    drive_op(32'h1234_5678, 16'h0000, 1'b1);
    collect(32'h1234_5678, 16'h0000, lat);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL latency_div_zero: got %0d required 1", lat);
    end
    // A normal completion right after must clear div_zero.
    drive_op(32'd20, 16'd6, 1'b1);
    collect(32'd20, 16'd6, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    int n;
    logic [RES_W-1:0] exp;
    exp = model(32'd5, 16'd9);
    drive_op(32'd5, 16'd9, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      dividend = 32'd77;
      divisor  = 16'd3;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== exp[31:0] || remainder !== exp[47:32] || div_zero !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: ov=%0b ir=%0b q=%h r=%h dz=%0b required 1/0/%h/%h/0",
                 i, out_valid, in_ready, quotient, remainder, div_zero, exp[31:0], exp[47:32]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    collect(32'd5, 16'd9, lat);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL busy_pulse_queued: ir=%0b ov=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit stale;
    drive_op(32'd1000, 16'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({quotient, remainder, div_zero, out_valid, in_ready, dbg_state} !== {32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_mid_calc: q=%h r=%h dz=%0b ov=%0b ir=%0b st=%0d required 0/0/0/0/1/0",
               quotient, remainder, div_zero, out_valid, in_ready, dbg_state);
    end
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) stale = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL stale_out_valid: saw out_valid=1 required 0 after reset");
    end
    drive_op(32'd1000, 16'd3, 1'b1);
    collect(32'd1000, 16'd3, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    time t0;
    time t1;
    drive_op(32'd999, 16'd10, 1'b1);
    t0 = $time;
    collect(32'd999, 16'd10, lat);
    drive_op(32'hDEAD_BEEF, 16'h1234, 1'b1);
    t1 = $time;
    collect(32'hDEAD_BEEF, 16'h1234, lat);
    checks++;
    if ((t1 - t0) / 10 != 34) begin
      failures++;
      $display("FAIL accept_interval: got %0d cycles required 34", (t1 - t0) / 10);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a;
    logic [15:0] b;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 16'h0000;
        1:       b = 16'h0001;
        2:       b = 16'hFFFF;
        3:       b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'($urandom_range(0, 65535));
        2:       a = 32'd0;
        default: a = $urandom;
      endcase
      drive_op(a, b, 1'b1);
      collect(a, b, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_results: got %0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
